// File: rtl/jts16_obj_scan_pkg.sv
// jts16_obj_scan_pkg: object table word indices, control bits and scanner FSM states
package jts16_obj_scan_pkg;
   localparam logic [2:0] W_YRANGE = 3'd0;
   localparam logic [2:0] W_X      = 3'd1;
   localparam logic [2:0] W_CTRL   = 3'd2;
   localparam logic [2:0] W_BASE   = 3'd3;
   localparam logic [2:0] W_ATTR   = 3'd4;
   localparam logic [2:0] W_ROW    = 3'd6;
   localparam int C_END   = 15;
   localparam int C_SKIP  = 14;
   localparam int C_HFLIP = 8;
   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CHK, S_FETCH, S_WB, S_HAND, S_NEXT} state_t;
   function automatic logic [10:0] waddr(input logic [6:0] idx, input logic [2:0] w);
      return {1'b0, idx, w};
   endfunction
endpackage

// File: rtl/jts16_obj_scan_match.sv
// jts16_obj_match: line range test and next ROM row offset for one object
module jts16_obj_match (
   input  logic [7:0]  line,
   input  logic [7:0]  top,
   input  logic [7:0]  bottom,
   input  logic [7:0]  pitch,
   input  logic [15:0] base,
   input  logic [15:0] row,
   output logic        hit,
   output logic [15:0] row_next
);
   always_comb begin
      hit      = line >= top && line < bottom;
      row_next = line == top ? base : row + {{8{pitch[7]}}, pitch};
   end
endmodule

// File: rtl/jts16_obj_scan.sv
// jts16_obj_scan: per-line object table walker, row offset write-back and drawer handoff
module jts16_obj_scan
   import jts16_obj_scan_pkg::*;
#(
   parameter int MAXOBJ = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hstart,
   input  logic [8:0]  vrender,
   output logic [10:0] tbl_addr,
   input  logic [15:0] tbl_dout,
   output logic        tbl_we,
   output logic [15:0] tbl_din,
   output logic        dr_start,
   input  logic        dr_busy,
   output logic [8:0]  dr_xpos,
   output logic [15:0] dr_offset,
   output logic [3:0]  dr_bank,
   output logic [5:0]  dr_pal,
   output logic        dr_hflip,
   output logic        scan_done
);
   state_t      st, st_nx;
   logic [6:0]  idx;
   logic [1:0]  cnt;
   logic [7:0]  line, pitch;
   logic        hflip_l;
   logic [8:0]  x_l;
   logic [15:0] base_l, yr_l, yr, row_nx;
   logic [5:0]  pal_l;
   logic [3:0]  bank_l;
   logic        hit, fire, last, unused_v;
   assign unused_v = vrender[8];
   // the Y range is tested straight off the RAM bus, then held for the row calculation
   assign yr   = st == S_CHK ? tbl_dout : yr_l;
   assign fire = st == S_HAND && !dr_busy && !dr_start;
   assign last = idx == 7'(MAXOBJ - 1);
   jts16_obj_match u_match (
      .line     (line),
      .top      (yr[7:0]),
      .bottom   (yr[15:8]),
      .pitch    (pitch),
      .base     (base_l),
      .row      (tbl_dout),
      .hit      (hit),
      .row_next (row_nx)
   );
   always_comb begin
      st_nx = st;
      if (hstart) st_nx = S_RD;
      else case (st)
         S_RD:    st_nx = S_WAIT;
         S_WAIT:  st_nx = S_CHK;
         S_CHK:   st_nx = cnt == 2'd0 ? (tbl_dout[C_END] ? S_IDLE : tbl_dout[C_SKIP] ? S_NEXT : S_CHK)
                                      : (hit ? S_FETCH : S_NEXT);
         S_FETCH: st_nx = cnt == 2'd3 ? S_WB : S_FETCH;
         S_WB:    st_nx = S_HAND;
         S_HAND:  st_nx = fire ? S_NEXT : S_HAND;
         S_NEXT:  st_nx = last ? S_IDLE : S_RD;
         default: st_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_IDLE;
         cnt       <= 2'd0;
         idx       <= 7'd0;
         line      <= 8'd0;
         pitch     <= 8'd0;
         hflip_l   <= 1'b0;
         x_l       <= 9'd0;
         base_l    <= 16'd0;
         yr_l      <= 16'd0;
         pal_l     <= 6'd0;
         bank_l    <= 4'd0;
         tbl_addr  <= 11'd0;
         tbl_we    <= 1'b0;
         tbl_din   <= 16'd0;
         dr_start  <= 1'b0;
         dr_xpos   <= 9'd0;
         dr_offset <= 16'd0;
         dr_bank   <= 4'd0;
         dr_pal    <= 6'd0;
         dr_hflip  <= 1'b0;
         scan_done <= 1'b1;
      end else begin
         st       <= st_nx;
         cnt      <= st_nx == st ? cnt + 2'd1 : 2'd0;
         tbl_we   <= 1'b0;
         dr_start <= 1'b0;
         if (hstart) begin
            line      <= vrender[7:0] + 8'd1;
            idx       <= 7'd0;
            scan_done <= 1'b0;
         end else case (st)
            S_RD:   tbl_addr <= waddr(idx, W_CTRL);
            S_WAIT: tbl_addr <= waddr(idx, W_YRANGE);
            S_CHK:
               if (cnt == 2'd0) begin
                  pitch     <= tbl_dout[7:0];
                  hflip_l   <= tbl_dout[C_HFLIP];
                  tbl_addr  <= waddr(idx, W_X);
                  scan_done <= tbl_dout[C_END];
               end else begin
                  yr_l     <= tbl_dout;
                  tbl_addr <= waddr(idx, W_BASE);
               end
            S_FETCH:
               case (cnt)
                  2'd0: begin
                     x_l      <= tbl_dout[8:0];
                     tbl_addr <= waddr(idx, W_ATTR);
                  end
                  2'd1: begin
                     base_l   <= tbl_dout;
                     tbl_addr <= waddr(idx, W_ROW);
                  end
                  2'd2: begin
                     pal_l  <= tbl_dout[13:8];
                     bank_l <= tbl_dout[3:0];
                  end
                  default: begin
                     tbl_din <= row_nx;
                     tbl_we  <= 1'b1;
                  end
               endcase
            S_HAND:
               if (fire) begin
                  dr_start  <= 1'b1;
                  dr_xpos   <= x_l;
                  dr_offset <= tbl_din;
                  dr_bank   <= bank_l;
                  dr_pal    <= pal_l;
                  dr_hflip  <= hflip_l;
               end
            S_NEXT:
               if (last) scan_done <= 1'b1;
               else idx <= idx + 7'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_jts16_obj_scan.sv
// tb_jts16_obj_scan: object RAM and drawer models around the scanner, checked against a table-walk model
module tb_jts16_obj_scan;
   typedef struct packed {
      logic [8:0]  x;
      logic [15:0] off;
      logic [3:0]  bank;
      logic [5:0]  pal;
      logic        hf;
   } draw_t;

   logic        clk = 0, rst = 1, hstart = 0;
   logic [8:0]  vrender = 0;
   logic [10:0] tbl_addr;
   logic [15:0] tbl_dout, tbl_din;
   logic        tbl_we, dr_start, dr_busy, dr_hflip, scan_done;
   logic [8:0]  dr_xpos;
   logic [15:0] dr_offset;
   logic [3:0]  dr_bank;
   logic [5:0]  dr_pal;

   logic [15:0] mem [2048];
   logic [15:0] ref_mem [2048];
   logic        tb_we = 0;
   logic [10:0] tb_a = 0;
   logic [15:0] tb_d = 0;
   logic        force_busy = 0;
   int          busy_cnt = 0;
   int          total = 0, bad = 0, wr_cnt = 0, bad_wr = 0, unstable = 0;
   int          nent = 0, cap_base = 0;
   draw_t       cap_q[$], exp_q[$];
   draw_t       cur, last_d = '0;

   always #5 clk = ~clk;

   jts16_obj_scan #(.MAXOBJ(128)) dut (
      .clk(clk), .rst(rst), .hstart(hstart), .vrender(vrender),
      .tbl_addr(tbl_addr), .tbl_dout(tbl_dout), .tbl_we(tbl_we), .tbl_din(tbl_din),
      .dr_start(dr_start), .dr_busy(dr_busy), .dr_xpos(dr_xpos), .dr_offset(dr_offset),
      .dr_bank(dr_bank), .dr_pal(dr_pal), .dr_hflip(dr_hflip), .scan_done(scan_done)
   );

   assign dr_busy = force_busy || busy_cnt != 0;
   assign cur = {dr_xpos, dr_offset, dr_bank, dr_pal, dr_hflip};

   // dual-port RAM (DUT port + bench loader port) and a drawer that stays busy a random time
   always @(posedge clk) begin
      tbl_dout <= mem[tbl_addr];
      if (tbl_we) mem[tbl_addr] <= tbl_din;
      if (tb_we) mem[tb_a] <= tb_d;
      busy_cnt <= rst ? 0 : dr_start ? int'($urandom_range(1, 12)) : busy_cnt > 0 ? busy_cnt - 1 : 0;
   end

   always @(negedge clk) begin
      if (tbl_we) begin
         wr_cnt++;
         if (tbl_addr[2:0] != 3'd6) bad_wr++;
      end
      if (dr_start) begin
         cap_q.push_back(cur);
         last_d = cur;
      end else if (!rst && cur != last_d) unstable++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      tb_a = 11'(a); tb_d = d; tb_we = 1; ref_mem[a] = d;
      @(posedge clk); #1 tb_we = 0;
   endtask

   task automatic set_entry(input int i, input logic [7:0] top, input logic [7:0] bot, input logic [8:0] x,
                            input logic [15:0] ctrl, input logic [15:0] base, input logic [15:0] attr,
                            input logic [15:0] row);
      logic [15:0] r;
      r = 16'($urandom);
      wr(i*8,   {bot, top});
      wr(i*8+1, {r[15:9], x});
      wr(i*8+2, ctrl);
      wr(i*8+3, base);
      wr(i*8+4, attr);
      wr(i*8+5, r);
      wr(i*8+6, row);
      wr(i*8+7, ~r);
      if (i + 1 > nent) nent = i + 1;
   endtask

   // walk the table as the hardware should for one line, updating the row words
   task automatic model_line(input logic [8:0] v);
      logic [7:0]  ln;
      logic [15:0] w0, w2, row;
      draw_t       d;
      ln = v[7:0] + 8'd1;
      exp_q.delete();
      for (int i = 0; i < 128; i++) begin
         w0 = ref_mem[i*8];
         w2 = ref_mem[i*8+2];
         if (w2[15]) break;
         if (!w2[14] && ln >= w0[7:0] && ln < w0[15:8]) begin
            row = ln == w0[7:0] ? ref_mem[i*8+3] : ref_mem[i*8+6] + {{8{w2[7]}}, w2[7:0]};
            ref_mem[i*8+6] = row;
            d = {ref_mem[i*8+1][8:0], row, ref_mem[i*8+4][3:0], ref_mem[i*8+4][13:8], w2[8]};
            exp_q.push_back(d);
         end
      end
   endtask

   task automatic pulse_h(input logic [8:0] v);
      cap_base = cap_q.size();
      @(posedge clk); #1 hstart = 1; vrender = v;
      @(posedge clk); #1 hstart = 0;
      check("scan_done_low", scan_done, 0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!scan_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, scan_done, 1);
   endtask

   task automatic cmp_draws(input string tag);
      check({tag, "_ndraw"}, cap_q.size() - cap_base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (cap_base + i < cap_q.size()) check({tag, "_draw"}, cap_q[cap_base+i], exp_q[i]);
      for (int i = 0; i < nent; i++) check({tag, "_w6"}, mem[i*8+6], ref_mem[i*8+6]);
      check({tag, "_wraddr"}, bad_wr, 0);
      check({tag, "_stable"}, unstable, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w_before;
      logic [7:0] l, top, bot;
      int endpos;
      logic [8:0] v;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_scan_done", scan_done, 1);
      check("rst_we", tbl_we, 0);
      check("rst_start", dr_start, 0);
      check("rst_dr", cur, 0);
      check("rst_addr", tbl_addr, 0);
      check("rst_din", tbl_din, 0);
      @(posedge clk); #1 rst = 0;

      // first line starts at top, second advances by the pitch
      set_entry(0, 8'h10, 8'h20, 9'h055, 16'h0004, 16'h1000, 16'h2A05, 16'hBEEF);
      set_entry(1, 8'h00, 8'hFF, 9'h0, 16'h8000, 16'h0, 16'h0, 16'h0);
      model_line(9'h00F); pulse_h(9'h00F); wait_done("l0f", 400); cmp_draws("l0f");
      check("l0f_off", dr_offset, 16'h1000);
      check("l0f_mem", mem[6], 16'h1000);
      model_line(9'h010); pulse_h(9'h010); wait_done("l10", 400); cmp_draws("l10");
      check("l10_off", dr_offset, 16'h1004);
      check("l10_mem", mem[6], 16'h1004);

      // skipped entry followed by end: no draws, no writes
      set_entry(0, 8'h00, 8'hFF, 9'h1, 16'h4000, 16'h1234, 16'h0, 16'h7777);
      set_entry(1, 8'h00, 8'hFF, 9'h2, 16'h8000, 16'h0, 16'h0, 16'h0);
      w_before = wr_cnt;
      model_line(9'h040); pulse_h(9'h040); wait_done("skip", 400); cmp_draws("skip");
      check("skip_nowrite", wr_cnt - w_before, 0);

      // negative pitch wraps below zero
      set_entry(0, 8'h10, 8'h30, 9'h1F0, 16'h01FE, 16'h5555, 16'h3F0F, 16'h0001);
      set_entry(1, 8'h00, 8'hFF, 9'h0, 16'h8000, 16'h0, 16'h0, 16'h0);
      model_line(9'h114); pulse_h(9'h114); wait_done("neg", 400); cmp_draws("neg");
      check("neg_off", dr_offset, 16'hFFFF);

      // drawer held busy: draws only after release, in table order
      for (int i = 0; i < 3; i++) set_entry(i, 8'h20, 8'h28, 9'(i + 1), 16'h0010, 16'(i * 16'h100), 16'h0101, 16'h0);
      set_entry(3, 8'h00, 8'hFF, 9'h0, 16'h8000, 16'h0, 16'h0, 16'h0);
      force_busy = 1;
      model_line(9'h021); pulse_h(9'h021);
      repeat (50) @(negedge clk);
      check("busy_nodraw", cap_q.size() - cap_base, 0);
      force_busy = 0;
      wait_done("busy", 800); cmp_draws("busy");
      for (int k = 0; k < 3; k++)
         if (cap_base + k < cap_q.size()) check("busy_order", cap_q[cap_base+k].x, k + 1);

      // restart while parked in the handoff
      set_entry(0, 8'h10, 8'h11, 9'h0AA, 16'h0002, 16'h0300, 16'h0000, 16'h0);
      set_entry(1, 8'h40, 8'h50, 9'h0BB, 16'h0003, 16'h0400, 16'h1203, 16'h0100);
      set_entry(2, 8'h00, 8'hFF, 9'h0, 16'h8000, 16'h0, 16'h0, 16'h0);
      force_busy = 1;
      model_line(9'h00F); pulse_h(9'h00F);
      repeat (30) @(negedge clk);
      check("restart_mid", scan_done, 0);
      check("stale_none", cap_q.size() - cap_base, 0);
      model_line(9'h044); pulse_h(9'h044);
      repeat (10) @(negedge clk);
      force_busy = 0;
      wait_done("restart", 800); cmp_draws("restart");

      // random tables; first one has no end marker so the scan runs to the last entry
      for (int t = 0; t < 4; t++) begin
         l = 8'($urandom);
         endpos = t == 0 ? 1000 : int'($urandom_range(3, 40));
         for (int i = 0; i < 128 && i <= endpos; i++) begin
            top = l - 8'($urandom_range(0, 4));
            bot = top + 8'($urandom_range(0, 8));
            set_entry(i, top, bot, 9'($urandom),
                      {i == endpos, $urandom_range(0, 4) == 0, 5'b0, 1'($urandom), 8'($urandom)},
                      16'($urandom), 16'($urandom), 16'($urandom));
         end
         for (int k = 0; k < 3; k++) begin
            v = {1'($urandom), 8'(l - 8'd1 + 8'(k))};
            model_line(v); pulse_h(v); wait_done("rnd", 8000); cmp_draws("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
